divisor_secuencial: RTL and testbench

- Sequential signed integer divider for the Execute-stage ALU, providing the inverse of the combinational signed multiplier.
- Computes quotient and remainder of two n-bit two's-complement operands using a restoring shift-subtract algorithm, one quotient bit per cycle.
- Uses a start/busy/done handshake so the ALU control can stall while it runs.
- Flag outputs follow the ALU convention: overflow and carry.

---
 rtl/divisor_secuencial.sv | 169 ++++++++++++++++
 tb/tb_divisor_secuencial.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per clock.
// Optional DIVISOR_EARLY_EXIT_EN finishes a divide-by-zero in a single cycle.
module divisor_secuencial #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] out,
  output logic [n-1:0] residuo,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         car
);

  localparam int CW = $clog2(n) + 1;
  localparam logic [n-1:0] ZERO_C = {n{1'b0}};
  localparam logic [n-1:0] ONES_C = {n{1'b1}};
  localparam logic [n-1:0] MIN_C  = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [n-1:0]   a_r, b_r, q_r, bmag_r, rem_r;
  logic           sign_q_r, sign_r_r;
  logic [CW-1:0]  cnt_r;
  logic           bzero_s, busy_s, done_s;
  logic [n:0]     shifted_s, diff_s;

  function automatic logic [n-1:0] neg2(input logic [n-1:0] v);
    return ~v + {{(n-1){1'b0}}, 1'b1};
  endfunction

  // |MIN| = 2^(n-1) is representable in the n-bit unsigned magnitude
  function automatic logic [n-1:0] abs2(input logic [n-1:0] v);
    return v[n-1] ? neg2(v) : v;
  endfunction

  assign bzero_s   = (B == ZERO_C);
  assign shifted_s = {rem_r, q_r[n-1]};
  assign diff_s    = shifted_s - {1'b0, bmag_r};
  assign car       = 1'b0;

  // State register with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
`ifdef DIVISOR_EARLY_EXIT_EN
          if (bzero_s) state_s = DONE;
          else         state_s = CALC;
`else
          state_s = CALC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(n-1)) state_s = FIX;
        else                   state_s = CALC;
      end
      FIX:     state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      CALC, FIX: busy_s = 1'b1;
      DONE:      done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= ZERO_C;
      b_r      <= ZERO_C;
      q_r      <= ZERO_C;
      bmag_r   <= ZERO_C;
      rem_r    <= ZERO_C;
      cnt_r    <= {CW{1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      out      <= ZERO_C;
      residuo  <= ZERO_C;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_r      <= A;
            b_r      <= B;
            q_r      <= abs2(A);
            bmag_r   <= abs2(B);
            rem_r    <= ZERO_C;
            cnt_r    <= {CW{1'b0}};
            sign_q_r <= A[n-1] ^ B[n-1];
            sign_r_r <= A[n-1];
`ifdef DIVISOR_EARLY_EXIT_EN
            if (bzero_s) begin
              out      <= ZERO_C;
              residuo  <= A;
              overflow <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          cnt_r <= cnt_r + CW'(1);
          // q_r shifts dividend bits out the top and quotient bits in the bottom
          if (!diff_s[n]) begin
            rem_r <= diff_s[n-1:0];
            q_r   <= {q_r[n-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s[n-1:0];
            q_r   <= {q_r[n-2:0], 1'b0};
          end
        end
        FIX: begin
          if (b_r == ZERO_C) begin
            out      <= ZERO_C;
            residuo  <= a_r;
            overflow <= 1'b1;
          end else begin
            // MIN / -1 yields magnitude 2^(n-1), which already wraps to MIN
            out      <= sign_q_r ? neg2(q_r) : q_r;
            residuo  <= sign_r_r ? neg2(rem_r) : rem_r;
            overflow <= (a_r == MIN_C) && (b_r == ONES_C);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial (n=8): directed cases from the plan plus
// randomized operands checked against plain signed arithmetic.
module tb_divisor_secuencial;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] A, B;
  logic [7:0] out, residuo;
  logic       busy, done, overflow, car;

  int checks = 0;
  int errors = 0;

  divisor_secuencial #(.n(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .out(out), .residuo(residuo), .busy(busy), .done(done),
    .overflow(overflow), .car(car)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division, remainder follows the dividend
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic ov);
    int sa, sb, iq, ir;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      iq = 0; ir = sa; ov = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      iq = -128; ir = 0; ov = 1'b1;
    end else begin
      iq = sa / sb; ir = sa % sb; ov = 1'b0;
    end
    q = iq[7:0];
    r = ir[7:0];
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef DIVISOR_EARLY_EXIT_EN
    if (b == 8'd0) return 1;
`endif
    return 10;
  endfunction

  // Run one operation from an idle/done state and check latency, busy profile and results
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0] eq, er;
    logic       eo;
    int         cyc;
    logic       busy_bad;
    model(a, b, eq, er, eo);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    cyc = 1;
    busy_bad = 1'b0;
    while (!done && cyc < 30) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat(b));
    chk({tag, "_busy_profile"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_out"}, {24'd0, out}, {24'd0, eq});
    chk({tag, "_residuo"}, {24'd0, residuo}, {24'd0, er});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, "_car"}, {31'd0, car}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_out_hold"}, {24'd0, out}, {24'd0, eq});
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0;
    #1;
    chk("reset_out", {24'd0, out}, 32'd0);
    chk("reset_residuo", {24'd0, residuo}, 32'd0);
    chk("reset_flags", {28'd0, busy, done, overflow, car}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'd100, 8'd7, "p_div");
    do_op(8'h9C, 8'd7, "n_dividend");
    do_op(8'd100, 8'hF9, "n_divisor");
    do_op(8'h80, 8'hFF, "min_by_m1");
    do_op(8'h80, 8'd1, "min_by_1");
    do_op(8'd55, 8'd0, "div_zero");
    do_op(8'h80, 8'd0, "min_by_zero");
    do_op(8'h7F, 8'h80, "max_by_min");

    // Back-to-back: mid-operation start ignored, start in DONE accepted
    @(negedge clk);
    A = 8'd9; B = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin @(negedge clk); cyc++; end
    A = 8'd1; B = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc++;
    while (!done && cyc < 30) begin @(negedge clk); cyc++; end
    chk("b2b_first_latency", cyc, 32'd10);
    chk("b2b_first_out", {24'd0, out}, 32'd4);
    chk("b2b_first_residuo", {24'd0, residuo}, 32'd1);
    A = 8'd20; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 30) begin @(negedge clk); cyc++; end
    chk("b2b_second_latency", cyc, 32'd10);
    chk("b2b_second_out", {24'd0, out}, 32'd6);
    chk("b2b_second_residuo", {24'd0, residuo}, 32'd2);

    // Asynchronous reset in cycle 5 of an operation
    @(negedge clk);
    A = 8'd50; B = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", {24'd0, out}, 32'd0);
    chk("async_rst_residuo", {24'd0, residuo}, 32'd0);
    chk("async_rst_flags", {28'd0, busy, done, overflow, car}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("async_rst_no_done", {31'd0, seen}, 32'd0);
    do_op(8'd50, 8'd5, "after_rst");

    // Randomized operands, with zero and extreme values mixed in
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k % 8 == 1) rb = 8'd0;
      if (k % 8 == 3) ra = 8'h80;
      if (k % 8 == 5) rb = 8'hFF;
      do_op(ra, rb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
